spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter DIV_RESET, default 8'd3, reset value of CTRL.clkdiv.
REQ-003 SHALL have port sys_clk  in  1  the single clock; all flops on rising edge.
REQ-004 SHALL have port cpu_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus_addr  in  4  byte address; bits[3:2] select register, bits[1:0] ignored.
REQ-006 SHALL have port bus_wdata  in  32  write data.
REQ-007 SHALL have port bus_we  in  1  single-cycle write strobe.
REQ-008 SHALL have port bus_re  in  1  single-cycle read strobe; never asserted together with bus_we.
REQ-009 SHALL have port bus_rdata  out  32  read data, registered, valid the cycle after bus_re, else holds its value.
REQ-010 SHALL have port spi_sck  out  1  SPI clock, mode 0.
REQ-011 SHALL have port spi_mosi  out  1  SPI data out, MSB first.
REQ-012 SHALL have port spi_miso  in  1  SPI data in.
REQ-013 SHALL have port spi_cs_n  out  1  chip select, active-low.
REQ-014 SHALL have port irq  out  1  level interrupt = CTRL.irq_en & STATUS.rx_valid.

Function
REQ-015 SHALL decode 0x0 DATA: write pushes bus_wdata[7:0] into the TX FIFO; read returns {24'b0, rx_byte} and clears rx_valid.
REQ-016 SHALL decode 0x4 STATUS (read): bit0 busy, bit1 tx_full, bit2 tx_empty, bit3 rx_valid, bit4 rx_ovr, bit5 tx_ovf; writing 1 to bit4/bit5 clears that bit.
REQ-017 SHALL decode 0x8 CTRL (R/W): bits[7:0] clkdiv, bit8 irq_en; other bits read 0; 0xC reads 0, writes ignored.
REQ-018 SHALL drop a DATA write when the FIFO is full and set sticky tx_ovf, unless a pop occurs the same cycle, in which case the write is accepted.
REQ-019 SHALL implement FSM states IDLE, SETUP, XFER, HOLD; busy = (state != IDLE).
REQ-020 SHALL define half-period H = clkdiv+1 sys_clk cycles, with clkdiv latched at each byte pop; CTRL writes mid-byte affect only the next byte.
REQ-021 IDLE with FIFO non-empty: SHALL pop a byte, drive spi_cs_n=0, spi_mosi=bit7, and enter SETUP for H cycles.
REQ-022 XFER: SHALL toggle spi_sck every H cycles for 16 half-periods; sample spi_miso on each rising sck edge; shift the next bit onto spi_mosi on each falling edge except the last.
REQ-023 At the end of the 16th half-period (sck low), SHALL write the received byte to rx_byte, set rx_valid, and set rx_ovr if rx_valid was already 1 and not being cleared that cycle.
REQ-024 A DATA read in the same cycle as byte completion SHALL return the old rx_byte, and leave rx_valid=1 with no rx_ovr.
REQ-025 At byte completion with FIFO non-empty, SHALL pop the next byte and continue XFER with spi_cs_n held low, without SETUP.
REQ-026 At byte completion with FIFO empty, SHALL enter HOLD for H cycles (cs low, sck low), then IDLE with spi_cs_n=1.
REQ-027 A byte frame SHALL occupy exactly 16*H cycles; an isolated single-byte transaction SHALL hold spi_cs_n low for 18*H cycles.
REQ-028 SHALL hold spi_sck low in IDLE, SETUP and HOLD.

Reset
REQ-029 On cpu_rst low, SHALL asynchronously force state=IDLE, FIFO empty, spi_sck=0, spi_mosi=0, spi_cs_n=1, bus_rdata=0, irq=0, rx_byte=0, all status bits 0, clkdiv=DIV_RESET, irq_en=0.
REQ-030 Reset asserted mid-transfer SHALL abort immediately (cs_n=1 asynchronously); after release, no partial byte is resumed or reported.

Verification
REQ-031 Reset, write DATA=0xA5 with clkdiv=3, miso tied 0 -> cs_n low 72 cycles, 8 sck pulses of 8 cycles each, mosi 1,0,1,0,0,1,0,1, rx_byte=0x00, rx_valid=1.
REQ-032 Loopback miso=mosi, write 0x3C,0xC3 back-to-back -> cs_n stays low across both bytes (136 cycles), read DATA between bytes returns 0x3C, then 0xC3 at end, no rx_ovr.
REQ-033 Write 6 bytes in consecutive cycles while IDLE, FIFO_DEPTH=4 -> first byte popped, 4 queued, 6th dropped, tx_ovf=1; exactly 5 frames transmitted.
REQ-034 Send two bytes without reading DATA -> rx_ovr=1, rx_byte=second byte; write STATUS=0x10 -> rx_ovr=0.
REQ-035 irq_en=1, one byte completes -> irq rises the completion cycle +1, falls after DATA read.
REQ-036 Assert cpu_rst during bit 3 of a frame -> cs_n=1, sck=0 immediately; after release STATUS reads 0x04, no irq.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - register-mapped mode-0 SPI master with TX FIFO
module spi_master_ctrl #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd3
) (
    input  logic        sys_clk,
    input  logic        cpu_rst,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  pop_data;

    logic [7:0]  clkdiv;
    logic        irq_en;
    logic [7:0]  div_lat;
    logic [7:0]  cnt;
    logic [3:0]  half_idx;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ovr;
    logic        tx_ovf;

    logic        half_end;
    logic        done;
    logic        pop;
    logic        push;
    logic        data_wr;
    logic        data_rd;
    logic        status_wr;
    logic        ctrl_wr;
    logic        busy;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:9]};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data   = fifo_mem[rd_ptr[AW-1:0]];

    assign data_wr   = bus_we && (bus_addr[3:2] == 2'd0);
    assign status_wr = bus_we && (bus_addr[3:2] == 2'd1);
    assign ctrl_wr   = bus_we && (bus_addr[3:2] == 2'd2);
    assign data_rd   = bus_re && (bus_addr[3:2] == 2'd0);

    assign half_end = (cnt == 8'd0);
    assign done     = (state == XFER) && half_end && (half_idx == 4'd15);
    assign pop      = !fifo_empty && ((state == IDLE) || done);
    // A full FIFO still takes the write if a byte leaves in the same cycle.
    assign push     = data_wr && (!fifo_full || pop);
    assign busy     = (state != IDLE);
    assign irq      = irq_en & rx_valid;

    always_comb begin
        rd_mux = 32'd0;
        case (bus_addr[3:2])
            2'd0:    rd_mux = {24'd0, rx_byte};
            2'd1:    rd_mux = {26'd0, tx_ovf, rx_ovr, rx_valid, fifo_empty, fifo_full, busy};
            2'd2:    rd_mux = {23'd0, irq_en, clkdiv};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
    end

    always_ff @(posedge sys_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            clkdiv    <= DIV_RESET;
            irq_en    <= 1'b0;
            rx_byte   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            tx_ovf    <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                clkdiv <= bus_wdata[7:0];
                irq_en <= bus_wdata[8];
            end
            if (data_wr && !push)
                tx_ovf <= 1'b1;
            else if (status_wr && bus_wdata[5])
                tx_ovf <= 1'b0;
            // Completion beats a simultaneous DATA read: the reader got the old byte.
            if (done && rx_valid && !data_rd)
                rx_ovr <= 1'b1;
            else if (status_wr && bus_wdata[4])
                rx_ovr <= 1'b0;
            if (done) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
            if (bus_re) bus_rdata <= rd_mux;
        end
    end

    always_ff @(posedge sys_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state    <= IDLE;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            cnt      <= 8'd0;
            div_lat  <= 8'd0;
            half_idx <= 4'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_sh    <= pop_data;
                        spi_mosi <= pop_data[7];
                        div_lat  <= clkdiv;
                        cnt      <= clkdiv;
                        spi_cs_n <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        cnt      <= div_lat;
                        half_idx <= 4'd0;
                        state    <= XFER;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                XFER: begin
                    if (!half_end) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        cnt      <= div_lat;
                        half_idx <= half_idx + 4'd1;
                        // Even half-periods end on a rising edge, odd ones on a falling edge.
                        if (!half_idx[0]) begin
                            spi_sck <= 1'b1;
                            rx_sh   <= {rx_sh[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (half_idx != 4'd15) begin
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                                spi_mosi <= tx_sh[6];
                            end else if (pop) begin
                                tx_sh    <= pop_data;
                                spi_mosi <= pop_data[7];
                                div_lat  <= clkdiv;
                                cnt      <= clkdiv;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl
module tb_spi_master_ctrl;
    logic        sys_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic [3:0]  bus_addr = 4'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;
    logic        irq;
    logic        loopback = 1'b0;
    logic        miso_val = 1'b0;

    assign spi_miso = loopback ? spi_mosi : miso_val;

    spi_master_ctrl #(.FIFO_DEPTH(4), .DIV_RESET(8'd3)) dut (
        .sys_clk(sys_clk), .cpu_rst(cpu_rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct { logic [31:0] val; string name; } rd_exp_t;
    typedef struct { int len; int pulses; } cs_exp_t;
    rd_exp_t    rd_q[$];
    logic [7:0] mosi_q[$];
    cs_exp_t    cs_q[$];
    int         cur_h = 4;

    // Register-read monitor
    logic rd_fire = 1'b0;
    always @(posedge sys_clk) rd_fire <= bus_re;
    always @(negedge sys_clk) begin
        rd_exp_t e;
        if (rd_fire) begin
            if (rd_q.size() == 0) check("rd_unexpected", bus_rdata, 32'hFFFF_FFFF);
            else begin
                e = rd_q.pop_front();
                check(e.name, bus_rdata, e.val);
            end
        end
    end

    // SPI line monitor
    int cs_cyc = 0, pulses = 0, hi_cnt = 0, lo_cnt = 0, nbits = 0;
    logic [7:0] sh = 8'd0;
    logic prev_sck = 1'b0, prev_cs = 1'b1;
    always @(negedge sys_clk) begin
        cs_exp_t c;
        if (!cpu_rst) begin
            cs_cyc = 0; pulses = 0; hi_cnt = 0; lo_cnt = 0; nbits = 0;
            prev_sck = 1'b0; prev_cs = 1'b1;
        end else begin
            if (!spi_cs_n) cs_cyc++;
            if (spi_sck && !prev_sck) begin
                if (pulses > 0) check("sck_low_width", lo_cnt, cur_h);
                pulses++;
                hi_cnt = 0;
                sh = {sh[6:0], spi_mosi};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (mosi_q.size() == 0) check("mosi_unexpected", {24'd0, sh}, 32'hFFFF_FFFF);
                    else check("mosi_byte", {24'd0, sh}, {24'd0, mosi_q.pop_front()});
                end
            end
            if (!spi_sck && prev_sck) begin
                check("sck_high_width", hi_cnt, cur_h);
                lo_cnt = 0;
            end
            if (spi_sck) hi_cnt++; else lo_cnt++;
            if (spi_cs_n && !prev_cs) begin
                if (cs_q.size() == 0) check("cs_unexpected", cs_cyc, 0);
                else begin
                    c = cs_q.pop_front();
                    check("cs_low_cycles", cs_cyc, c.len);
                    check("sck_pulses", pulses, c.pulses);
                end
                cs_cyc = 0; pulses = 0; nbits = 0;
            end
            prev_sck = spi_sck;
            prev_cs  = spi_cs_n;
        end
    end

    // Bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(posedge sys_clk); #1;
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.val = exp; e.name = name;
        rd_q.push_back(e);
        bus_addr = a; bus_re = 1'b1;
        @(posedge sys_clk); #1;
        bus_re = 1'b0;
    endtask

    task automatic expect_frame(input int len, input int npulse);
        cs_exp_t c;
        c.len = len; c.pulses = npulse;
        cs_q.push_back(c);
    endtask

    task automatic wait_cs_low(input int limit);
        int n;
        n = 0;
        while (spi_cs_n && n < limit) begin @(negedge sys_clk); n++; end
        check("frame_start_timeout", spi_cs_n, 1'b0);
    endtask

    task automatic wait_frame(input int limit);
        int n;
        wait_cs_low(limit);
        n = 0;
        while (!spi_cs_n && n < limit) begin @(negedge sys_clk); n++; end
        check("frame_end_timeout", spi_cs_n, 1'b1);
        @(posedge sys_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int irq_cyc;
        int lows;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_rdata", bus_rdata, 32'd0);
        cpu_rst = 1'b1;
        @(posedge sys_clk); #1;
        bus_read(4'h4, 32'h04, "rst_status");
        bus_read(4'h8, 32'h003, "rst_ctrl");
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, 32'h0, "reg_c_zero");
        bus_read(4'h8, 32'h003, "ctrl_after_c_write");

        // Single byte, clkdiv=3, miso low
        cur_h = 4;
        mosi_q.push_back(8'hA5);
        expect_frame(72, 8);
        bus_write(4'h0, 32'hA5);
        wait_frame(500);
        bus_read(4'h4, 32'h0C, "a5_status");
        bus_read(4'h0, 32'h00, "a5_rx_byte");
        bus_read(4'h4, 32'h04, "a5_status_cleared");

        // Back-to-back loopback pair
        loopback = 1'b1;
        mosi_q.push_back(8'h3C);
        mosi_q.push_back(8'hC3);
        expect_frame(136, 16);
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'hC3);
        wait_cs_low(100);
        repeat (80) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        bus_read(4'h0, 32'h3C, "pair_first_byte");
        wait_frame(500);
        bus_read(4'h4, 32'h0C, "pair_status");
        bus_read(4'h0, 32'hC3, "pair_second_byte");
        bus_read(4'h4, 32'h04, "pair_status_cleared");

        // Overflow: six consecutive writes into a depth-4 FIFO, clkdiv=0
        loopback = 1'b0;
        cur_h = 1;
        bus_write(4'h8, 32'h000);
        for (int i = 0; i < 5; i++) mosi_q.push_back(8'h11 + 8'(i));
        expect_frame(82, 40);
        for (int i = 0; i < 6; i++) bus_write(4'h0, 32'h11 + i);
        wait_frame(500);
        bus_read(4'h4, 32'h3C, "ovf_status");
        bus_write(4'h4, 32'h30);
        bus_read(4'h4, 32'h0C, "ovf_status_cleared");
        bus_read(4'h0, 32'h00, "ovf_rx_byte");
        bus_read(4'h4, 32'h04, "ovf_status_idle");

        // RX overrun, clkdiv=1
        loopback = 1'b1;
        cur_h = 2;
        bus_write(4'h8, 32'h001);
        mosi_q.push_back(8'h5A);
        expect_frame(36, 8);
        bus_write(4'h0, 32'h5A);
        wait_frame(500);
        mosi_q.push_back(8'h96);
        expect_frame(36, 8);
        bus_write(4'h0, 32'h96);
        wait_frame(500);
        bus_read(4'h4, 32'h1C, "ovr_status");
        bus_write(4'h4, 32'h10);
        bus_read(4'h4, 32'h0C, "ovr_status_cleared");
        bus_read(4'h0, 32'h96, "ovr_rx_byte");
        bus_read(4'h4, 32'h04, "ovr_status_idle");

        // DATA read coinciding with byte completion, clkdiv=0
        cur_h = 1;
        bus_write(4'h8, 32'h000);
        mosi_q.push_back(8'h42);
        expect_frame(18, 8);
        bus_write(4'h0, 32'h42);
        wait_frame(500);
        mosi_q.push_back(8'hE7);
        expect_frame(18, 8);
        bus_write(4'h0, 32'hE7);
        repeat (17) @(posedge sys_clk);
        #1;
        bus_read(4'h0, 32'h42, "rd_at_done_old_byte");
        wait_frame(500);
        bus_read(4'h4, 32'h0C, "rd_at_done_status");
        bus_read(4'h0, 32'hE7, "rd_at_done_new_byte");

        // Interrupt timing, clkdiv=3, irq_en=1
        cur_h = 4;
        bus_write(4'h8, 32'h103);
        bus_read(4'h8, 32'h103, "ctrl_irq_en");
        mosi_q.push_back(8'h81);
        expect_frame(72, 8);
        bus_write(4'h0, 32'h81);
        n = 0; irq_cyc = -1; lows = 0;
        while (n < 300 && irq_cyc < 0) begin
            @(negedge sys_clk);
            n++;
            if (!spi_cs_n) lows++;
            if (irq) irq_cyc = lows;
        end
        check("irq_rise_cycle", irq_cyc, 69);
        wait_frame(500);
        check("irq_held", irq, 1'b1);
        bus_read(4'h0, 32'h81, "irq_rx_byte");
        check("irq_after_read", irq, 1'b0);

        // Reset during bit 3 of a frame
        loopback = 1'b0;
        bus_write(4'h0, 32'hFF);
        wait_cs_low(100);
        repeat (29) @(negedge sys_clk);
        #2;
        cpu_rst = 1'b0;
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sck", spi_sck, 1'b0);
        check("abort_mosi", spi_mosi, 1'b0);
        check("abort_irq", irq, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        cpu_rst = 1'b1;
        @(posedge sys_clk); #1;
        bus_read(4'h4, 32'h04, "abort_status");
        bus_read(4'h8, 32'h003, "abort_ctrl");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (!spi_cs_n || irq) lows++;
        end
        check("abort_no_resume", lows, 0);

        repeat (4) @(posedge sys_clk);
        check("rd_q_drained", rd_q.size(), 0);
        check("mosi_q_drained", mosi_q.size(), 0);
        check("cs_q_drained", cs_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
